light_pwm_driver: RTL

Downstream consumer of the 3-bit brightness level produced by the light level counter. It converts the level (0–4) plus the `on` enable into a glitch-free PWM drive for the LED. Brightness changes fade linearly, with the duty updated only on PWM period boundaries. It also exposes the applied duty and a fade-in-progress flag for status display.

---
 rtl/light_pwm_driver.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/light_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module   : light_pwm_driver
//  Purpose  : Maps a 0..4 brightness level to a PWM duty, fading linearly
//             between targets with duty updates only on period boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
module light_pwm_driver #(
    parameter int PWM_BITS  = 8,
    parameter int PRESCALE  = 4,
    parameter int FADE_STEP = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                on,
    input  logic [2:0]          level,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] duty,
    output logic                busy
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PRE_W-1:0]    C_PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] C_MAX      = '1;
    localparam logic [PWM_BITS-1:0] C_Q1       = {2'b01, {(PWM_BITS-2){1'b0}}};
    localparam logic [PWM_BITS-1:0] C_Q2       = {2'b10, {(PWM_BITS-2){1'b0}}};
    localparam logic [PWM_BITS-1:0] C_Q3       = {2'b11, {(PWM_BITS-2){1'b0}}};
    localparam logic [PWM_BITS:0]   C_STEP     = (PWM_BITS+1)'(FADE_STEP);
    localparam logic [PWM_BITS-1:0] C_STEP_N   = PWM_BITS'(FADE_STEP);

    typedef enum logic [1:0] {
        ST_STEADY = 2'd0,
        ST_UP     = 2'd1,
        ST_DOWN   = 2'd2
    } state_t;

    state_t              state_q,   state_d;
    logic [PRE_W-1:0]    pre_q,     pre_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] target_q,  target_d;
    logic [PWM_BITS-1:0] duty_q,    duty_d;
    logic                pwm_out_q, pwm_out_d;

    logic                tick;
    logic                boundary;
    logic [PWM_BITS:0]   duty_ext;
    logic [PWM_BITS:0]   target_ext;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS-1:0] up_next;
    logic [PWM_BITS-1:0] down_next;

    // Level to target map; out-of-range levels saturate at full brightness.
    always_comb begin
        target_d = '0;
        if (on) begin
            case (level)
                3'd0:    target_d = '0;
                3'd1:    target_d = C_Q1;
                3'd2:    target_d = C_Q2;
                3'd3:    target_d = C_Q3;
                default: target_d = C_MAX;
            endcase
        end
    end

    always_comb begin
        tick      = (pre_q == C_PRE_LAST);
        pre_d     = tick ? '0 : pre_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        boundary  = tick && (pwm_cnt_q == C_MAX);
    end

    // One extra bit of headroom so the step never wraps before saturating.
    always_comb begin
        duty_ext   = {1'b0, duty_q};
        target_ext = {1'b0, target_q};
        up_sum     = duty_ext + C_STEP;
        up_next    = (up_sum >= target_ext) ? target_q : up_sum[PWM_BITS-1:0];
        down_next  = (duty_ext <= target_ext + C_STEP) ? target_q : duty_q - C_STEP_N;
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        case (state_q)
            ST_STEADY: begin
                if (duty_q < target_q) begin
                    state_d = ST_UP;
                end else if (duty_q > target_q) begin
                    state_d = ST_DOWN;
                end
            end
            ST_UP: begin
                if (duty_q > target_q) begin
                    state_d = ST_DOWN;
                end else if (duty_q == target_q) begin
                    state_d = ST_STEADY;
                end else if (boundary) begin
                    duty_d = up_next;
                    if (up_next == target_q) begin
                        state_d = ST_STEADY;
                    end
                end
            end
            ST_DOWN: begin
                if (duty_q < target_q) begin
                    state_d = ST_UP;
                end else if (duty_q == target_q) begin
                    state_d = ST_STEADY;
                end else if (boundary) begin
                    duty_d = down_next;
                    if (down_next == target_q) begin
                        state_d = ST_STEADY;
                    end
                end
            end
            default: state_d = ST_STEADY;
        endcase
    end

    // Full duty is forced high so the LED does not blink once per period.
    always_comb begin
        pwm_out_d = (duty_q == C_MAX) || (pwm_cnt_q < duty_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_STEADY;
            pre_q     <= '0;
            pwm_cnt_q <= '0;
            target_q  <= '0;
            duty_q    <= '0;
            pwm_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            pwm_cnt_q <= pwm_cnt_d;
            target_q  <= target_d;
            duty_q    <= duty_d;
            pwm_out_q <= pwm_out_d;
        end
    end

    assign pwm_out = pwm_out_q;
    assign duty    = duty_q;
    assign busy    = (state_q != ST_STEADY);

endmodule
`default_nettype wire
